// File: rtl/psa_pkg.sv
// Shared types and default parameters for the pulse synchronizer arbiter.
package psa_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } psa_state_e;

  localparam int unsigned PSA_N_REQ       = 4;
  localparam int unsigned PSA_CNT_W       = 4;
  localparam int unsigned PSA_GAP_CYC     = 2;
  localparam int unsigned PSA_TIMEOUT_CYC = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_arbiter
  import psa_pkg::*;
#(
  parameter int unsigned N_REQ = PSA_N_REQ,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_c_o,
  output logic [ID_W-1:0]  idx_c_o,
  output logic             any_c_o
);

  // Scan N_REQ slots starting at the pointer; first hit wins.
  always_comb begin
    int unsigned pos;
    logic [ID_W-1:0] slot;
    gnt_c_o = '0;
    idx_c_o = '0;
    any_c_o = 1'b0;
    pos     = 0;
    slot    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      slot = ID_W'(pos);
      if (!any_c_o && req_i[slot]) begin
        any_c_o       = 1'b1;
        gnt_c_o[slot] = 1'b1;
        idx_c_o       = slot;
      end
    end
  end

endmodule

// File: rtl/pulse_sync_arbiter.sv
// Shares one clka->clkb pulse synchronizer among N_REQ requesters.
// Optional: define PSA_TIMEOUT_EN to abort WAIT_ACK after TIMEOUT_CYC cycles.
module pulse_sync_arbiter
  import psa_pkg::*;
#(
  parameter int unsigned N_REQ       = PSA_N_REQ,
  parameter int unsigned CNT_W       = PSA_CNT_W,
  parameter int unsigned GAP_CYC     = PSA_GAP_CYC,
  parameter int unsigned TIMEOUT_CYC = PSA_TIMEOUT_CYC,
  parameter int unsigned ID_W        = $clog2(N_REQ)
) (
  input  logic             clka,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_pulse,
  input  logic             sync_ack,
  output logic             sync_pulse,
  output logic [ID_W-1:0]  sync_id,
  output logic             busy,
  output logic [N_REQ-1:0] ovf,
  output logic             timeout_err
);

  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

  psa_state_e       state_q, state_d;
  logic [ID_W-1:0]  sync_id_q, sync_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             sync_pulse_q, sync_pulse_d;
  logic             busy_q, busy_d;
  logic [N_REQ-1:0] nz_c;
  logic [N_REQ-1:0] win_gnt_c;
  logic [ID_W-1:0]  win_idx_c;
  logic             any_c;
  logic             tmo_exp_c;

  // Per-requester saturating pending counters and sticky overflow flags.
  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             inc_c, dec_c;

    assign inc_c = req_pulse[g];
    assign dec_c = (state_q == ISSUE) && gnt_q[g];

    // Net change: increment saturates into ovf; inc and dec together cancel.
    always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (inc_c && !dec_c) begin
        if (cnt_q == '1) ovf_d = 1'b1;
        else             cnt_d = cnt_q + CNT_W'(1);
      end else if (dec_c && !inc_c) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    // Counter state register.
    always_ff @(posedge clka) begin
      if (rst) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        ovf_q <= ovf_d;
      end
    end

    assign nz_c[g] = (cnt_q != '0);
    assign ovf[g]  = ovf_q;
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .req_i   (nz_c),
    .ptr_i   (rr_ptr_q),
    .gnt_c_o (win_gnt_c),
    .idx_c_o (win_idx_c),
    .any_c_o (any_c)
  );

`ifdef PSA_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TMO_W-1:0] tmo_q;
  logic             terr_q;

  // WAIT_ACK cycle budget, reloaded while in ISSUE so each wait starts fresh.
  always_ff @(posedge clka) begin
    if (rst)                                       tmo_q <= '0;
    else if (state_q == ISSUE)                     tmo_q <= TMO_W'(TIMEOUT_CYC - 1);
    else if (state_q == WAIT_ACK && tmo_q != '0)   tmo_q <= tmo_q - TMO_W'(1);
  end

  assign tmo_exp_c = (state_q == WAIT_ACK) && !sync_ack && (tmo_q == '0);

  // Sticky timeout flag.
  always_ff @(posedge clka) begin
    if (rst)            terr_q <= 1'b0;
    else if (tmo_exp_c) terr_q <= 1'b1;
  end

  assign timeout_err = terr_q;
`else
  assign tmo_exp_c   = 1'b0;
  // Constant zero; the term only keeps TIMEOUT_CYC referenced in this build.
  assign timeout_err = 1'b0 && (TIMEOUT_CYC != 0);
`endif

  // Next-state, grant capture and registered-output decode.
  always_comb begin
    state_d      = state_q;
    sync_id_d    = sync_id_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    gap_d        = gap_q;
    sync_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_c) begin
          state_d      = ISSUE;
          sync_id_d    = win_idx_c;
          gnt_d        = win_gnt_c;
          rr_ptr_d     = (win_idx_c == ID_W'(N_REQ - 1)) ? '0 : win_idx_c + ID_W'(1);
          sync_pulse_d = 1'b1;
        end
      end
      ISSUE: state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (sync_ack || tmo_exp_c) begin
          if (GAP_CYC == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = GAP_W'(GAP_CYC);
          end
        end
      end
      GAP: begin
        if (gap_q <= GAP_W'(1)) state_d = IDLE;
        else                    gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // FSM and output registers.
  always_ff @(posedge clka) begin
    if (rst) begin
      state_q      <= IDLE;
      sync_id_q    <= '0;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      gap_q        <= '0;
      sync_pulse_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_id_q    <= sync_id_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      gap_q        <= gap_d;
      sync_pulse_q <= sync_pulse_d;
      busy_q       <= busy_d;
    end
  end

  assign sync_pulse = sync_pulse_q;
  assign sync_id    = sync_id_q;
  assign busy       = busy_q;

endmodule

// File: doc/pulse_sync_arbiter.md
# pulse_sync_arbiter

Source-domain (clka) controller that shares one clka→clkb pulse synchronizer among N_REQ requesters. It collects single-cycle event pulses per requester in saturating pending counters and grants the synchronizer round-robin. For each grant it drives one pulse plus a stable channel ID, then waits for the returned acknowledge and a guard gap before the next issue. This guarantees the synchronizer never sees pulses closer than its round-trip handshake allows.

## Interface
- N_REQ, 4, number of requesters (2..16)
- CNT_W, 4, width of each per-requester pending counter
- GAP_CYC, 2, idle guard cycles after ack before next issue (0 allowed)
- TIMEOUT_CYC, 64, WAIT_ACK cycles before abort (used only with PSA_TIMEOUT_EN)
- ID_W, $clog2(N_REQ), width of sync_id
- clka  in  1  sole clock (source domain of the synchronizer)
- rst  in  1  synchronous, active-high reset
- req_pulse  in  N_REQ  single-cycle event per requester; multiple bits may be high together
- sync_ack  in  1  single-cycle ack from destination, already resynchronized to clka
- sync_pulse  out  1  one-cycle pulse to synchronizer pulse_ina
- sync_id  out  ID_W  requester index of current transfer, stable from ISSUE through GAP
- busy  out  1  high in any state except IDLE
- ovf  out  N_REQ  sticky per-requester counter-saturation flag
- timeout_err  out  1  sticky ack-timeout flag (constant 0 without PSA_TIMEOUT_EN)

## Operation
- Reset: state IDLE, all counters 0, rr pointer 0, sync_pulse 0, sync_id 0, busy 0, ovf 0, timeout_err 0.
- Pending counters: +1 on req_pulse[i]; −1 when i is granted (ISSUE cycle); both in the same cycle → unchanged. At max (2^CNT_W−1), an increment is dropped and sets ovf[i]; ovf clears only on reset.
- Arbitration in IDLE: among counters ≠0, pick the first index at or after the rr pointer, wrapping mod N_REQ. Register the winner into sync_id, set rr pointer = winner+1 mod N_REQ, go to ISSUE.
- FSM:
  - IDLE → ISSUE when any counter ≠0.
  - ISSUE: sync_pulse=1 for exactly this cycle; decrement the granted counter; → WAIT_ACK.
  - WAIT_ACK: on sync_ack → GAP (load GAP_CYC), or → IDLE directly if GAP_CYC=0.
  - GAP: count down; on reaching 0 → IDLE.
- sync_ack outside WAIT_ACK is ignored, including in the ISSUE cycle.
- A request arriving during ISSUE/WAIT_ACK/GAP is only counted. This includes a request from the granted requester.
- Reset mid-transfer aborts immediately. Any in-flight synchronizer pulse is not tracked, and its later ack arrives in IDLE and is ignored.

## Timing
- req_pulse at cycle t (counter idle, FSM idle) → counter ≠0 at t+1 → sync_pulse high at t+2.
- Minimum issue-to-issue spacing: 1 (ISSUE) + ack wait (≥1) + GAP_CYC + 1 (IDLE) cycles.
- sync_id changes only on the IDLE→ISSUE transition.
- busy is registered with the state and is high from the ISSUE cycle through the last GAP cycle.

## Configuration
- PSA_TIMEOUT_EN defined: a WAIT_ACK cycle counter is instantiated. After TIMEOUT_CYC cycles without sync_ack, the FSM sets timeout_err (sticky) and goes to GAP as if acked. The counter is reloaded on each WAIT_ACK entry.
- Not defined: no counter; WAIT_ACK waits indefinitely; timeout_err tied to 0.

## Structure
- Shared package psa_pkg: state enum (IDLE, ISSUE, WAIT_ACK, GAP) and default parameter constants.
- One sub-module, rr_arbiter (N_REQ-bit request vector + pointer → one-hot grant + index, combinational). Counters and FSM stay in the top.

## Test plan
- Single request: req_pulse=4'b0010 at t → sync_pulse at t+2, sync_id=1, busy high. sync_ack 3 cycles later → GAP 2 cycles → IDLE, busy 0.
- Simultaneous 4'b1111 with immediate acks → issue order ids 0,1,2,3, each exactly once; all counters end at 0.
- Fairness: req 0 pulses every cycle, req 2 pulses once → grants alternate 0,2,0, and requester 0 never starves 2.
- Saturation: 16 pulses on req 3 while blocked in WAIT_ACK → counter 15, ovf[3]=1 and stays 1; exactly 15 issues for id 3 after acks.
- Same-cycle inc/dec: req_pulse[1] during its own ISSUE cycle → counter unchanged, one further issue for id 1. Ack asserted during ISSUE → ignored, FSM stays in WAIT_ACK.
- With PSA_TIMEOUT_EN, TIMEOUT_CYC=8, no ack → timeout_err at WAIT_ACK cycle 8, then GAP and the next grant proceeds. Reset mid-WAIT_ACK → all outputs return to reset values in the next cycle.
